// File: rtl/seg_display_scanner_pkg.sv
// Shared definitions for the seven-segment scanner.
//   state_t   : scan FSM encoding (OFF / SHOW / GAP)
//   SEG_BLANK : all segments off (active-low)
//   HEX_SEG   : 16-entry hex-to-segment table, gfedcba, active-low
package seg_display_scanner_pkg;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_SHOW,
    ST_GAP
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Element [n] is the pattern for nibble n (index 15 written first).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/seg_display_scanner_hex_to_seg.sv
// Combinational hex nibble to seven-segment decoder.
//   nibble : 4-bit hex digit
//   seg    : active-low segments, seg[0]=a ... seg[6]=g
module hex_to_seg
  import seg_display_scanner_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_SEG[nibble];
  end

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// Rotates one active-low anode across the digits with optional dead time,
// decodes a frame-stable snapshot of the value, and supports blanking,
// decimal points and leading-zero suppression.
//   clk, reset  : clock, async active-high reset
//   en          : display enable (0 = dark, restart at digit 0)
//   value       : NUM_DIGITS hex nibbles, digit 0 rightmost
//   dp_in       : decimal point request per digit
//   blank_mask  : per-digit force-dark
//   lz_en       : leading-zero suppression enable
//   an          : anodes, active-low
//   seg, dp     : segments / decimal point, active-low
//   frame_tick  : one-cycle pulse on each frame wrap
module seg_display_scanner
  import seg_display_scanner_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned PRESCALE    = 50000,
  parameter int unsigned DEAD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_MAX = (PRESCALE > DEAD_CYCLES) ? PRESCALE : DEAD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  state_t                  state, state_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [4*NUM_DIGITS-1:0] snap_value, snap_value_n;
  logic [NUM_DIGITS-1:0]   snap_dp, snap_dp_n;
  logic [NUM_DIGITS-1:0]   snap_blank, snap_blank_n;
  logic                    snap_lz, snap_lz_n;
  logic                    tick_n;
  logic                    advance, load;

  logic [NUM_DIGITS-1:0]   suppressed;
  logic                    leading;
  logic [3:0]              nibble_n;
  logic [6:0]              hex_seg;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [6:0]              seg_n;
  logic                    dp_n;

  // Scan sequencing and snapshot capture.
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    cnt_n        = cnt;
    snap_value_n = snap_value;
    snap_dp_n    = snap_dp;
    snap_blank_n = snap_blank;
    snap_lz_n    = snap_lz;
    tick_n       = 1'b0;
    advance      = 1'b0;
    load         = 1'b0;

    if (!en) begin
      state_n = ST_OFF;
      idx_n   = '0;
      cnt_n   = '0;
    end else begin
      unique case (state)
        ST_OFF: begin
          load    = 1'b1;
          state_n = ST_SHOW;
          idx_n   = '0;
          cnt_n   = '0;
        end
        ST_SHOW: begin
          if (cnt == SHOW_LAST) begin
            cnt_n = '0;
            if (DEAD_CYCLES > 0) state_n = ST_GAP;
            else                 advance = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt_n   = '0;
            state_n = ST_SHOW;
            advance = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = ST_OFF;
      endcase

      if (advance) begin
        if (idx == IDX_LAST) begin
          idx_n  = '0;
          load   = 1'b1;
          tick_n = 1'b1;
        end else begin
          idx_n = idx + 1'b1;
        end
      end

      if (load) begin
        snap_value_n = value;
        snap_dp_n    = dp_in;
        snap_blank_n = blank_mask;
        snap_lz_n    = lz_en;
      end
    end
  end

  // Leading-zero mask on the next snapshot, scanning from the top digit;
  // digit 0 is excluded so a zero value still shows one '0'.
  always_comb begin
    suppressed = '0;
    leading    = snap_lz_n;
    for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (leading && (snap_value_n[4*k +: 4] == 4'h0)) suppressed[k] = 1'b1;
      else                                            leading       = 1'b0;
    end
  end

  always_comb begin
    nibble_n = snap_value_n[{idx_n, 2'b00} +: 4];
  end

  hex_to_seg u_hex_to_seg (
    .nibble (nibble_n),
    .seg    (hex_seg)
  );

  // Outputs are computed from next-state values so they register on the
  // same edge that moves the state/index.
  always_comb begin
    an_n  = '1;
    seg_n = SEG_BLANK;
    dp_n  = 1'b1;
    if ((state_n == ST_SHOW) && !(snap_blank_n[idx_n] || suppressed[idx_n])) begin
      an_n[idx_n] = 1'b0;
      seg_n       = hex_seg;
      dp_n        = ~snap_dp_n[idx_n];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_OFF;
      idx        <= '0;
      cnt        <= '0;
      snap_value <= '0;
      snap_dp    <= '0;
      snap_blank <= '0;
      snap_lz    <= 1'b0;
      an         <= '1;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      snap_value <= snap_value_n;
      snap_dp    <= snap_dp_n;
      snap_blank <= snap_blank_n;
      snap_lz    <= snap_lz_n;
      an         <= an_n;
      seg        <= seg_n;
      dp         <= dp_n;
      frame_tick <= tick_n;
    end
  end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner with NUM_DIGITS=4,
// PRESCALE=4, DEAD_CYCLES=1 (20-cycle frame).
module tb_seg_display_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic        lz_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  seg_display_scanner #(
    .NUM_DIGITS  (4),
    .PRESCALE    (4),
    .DEAD_CYCLES (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .value      (value),
    .dp_in      (dp_in),
    .blank_mask (blank_mask),
    .lz_en      (lz_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp_in;
    logic [3:0]      blank;
    logic            lz;
    logic [3:0]      lit;   // digits expected to light
    logic [3:0][6:0] seg;   // expected pattern per digit {d3,d2,d1,d0}
    logic [3:0]      dpo;   // expected dp output per digit (active-low)
  } vec_t;

  vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] ea, input logic [6:0] es,
                       input logic ed, input logic et);
    total++;
    if (an === ea && seg === es && dp === ed && frame_tick === et)
      passed++;
    else
      $display("FAIL %s: got an=%b seg=%b dp=%b tick=%b, expected an=%b seg=%b dp=%b tick=%b",
               name, an, seg, dp, frame_tick, ea, es, ed, et);
  endtask

  task automatic check_dark(input string name);
    check(name, 4'hF, 7'h7F, 1'b1, 1'b0);
  endtask

  // Called at digit 0 cycle 0 of a frame; checks all 20 cycles and leaves
  // the bench at digit 0 cycle 0 of the following frame.
  task automatic run_frame(input string name, input vec_t v, input logic first_tick,
                           input int chg_at, input logic [15:0] chg_val);
    for (int t = 0; t < 20; t++) begin
      int k;
      int c;
      logic [3:0] ea;
      logic [6:0] es;
      logic       ed;
      k  = t / 5;
      c  = t % 5;
      ea = 4'hF;
      es = 7'h7F;
      ed = 1'b1;
      if (c < 4 && v.lit[k]) begin
        ea[k] = 1'b0;
        es    = v.seg[k];
        ed    = v.dpo[k];
      end
      check($sformatf("%s t=%0d", name, t), ea, es, ed, (t == 0) ? first_tick : 1'b0);
      if (t == chg_at) value = chg_val;
      step();
    end
  endtask

  task automatic apply(input vec_t v);
    en = 1'b0;
    step();
    value      = v.value;
    dp_in      = v.dp_in;
    blank_mask = v.blank;
    lz_en      = v.lz;
    en         = 1'b1;
    step();
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, 4'b0000, 1'b0, 4'b1111, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
    vecs[1] = '{16'h0050, 4'b1000, 4'b0000, 1'b1, 4'b0011, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111};
    vecs[2] = '{16'h0000, 4'b0001, 4'b0000, 1'b1, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1110};
    vecs[3] = '{16'h1234, 4'b1001, 4'b0100, 1'b0, 4'b1011, {7'h79, 7'h7F, 7'h30, 7'h19}, 4'b0110};
    vecs[4] = '{16'hABCD, 4'b0000, 4'b0000, 1'b1, 4'b1111, {7'h08, 7'h03, 7'h46, 7'h21}, 4'b1111};
    vecs[5] = '{16'h0F00, 4'b0010, 4'b0000, 1'b1, 4'b0111, {7'h7F, 7'h0E, 7'h40, 7'h40}, 4'b1101};
    vecs[6] = '{16'h5678, 4'b0000, 4'b0000, 1'b0, 4'b1111, {7'h12, 7'h02, 7'h78, 7'h00}, 4'b1111};

    reset      = 1'b1;
    en         = 1'b0;
    value      = 16'h0;
    dp_in      = 4'h0;
    blank_mask = 4'h0;
    lz_en      = 1'b0;

    // Reset held, then released with en=0.
    #1;
    check_dark("reset async");
    for (int i = 0; i < 3; i++) begin
      step();
      check_dark($sformatf("reset held %0d", i));
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_dark($sformatf("idle en=0 %0d", i));
    end

    // Table: each configuration for two frames; the second starts on a wrap.
    for (int i = 0; i < 6; i++) begin
      apply(vecs[i]);
      run_frame($sformatf("vec%0d f1", i), vecs[i], 1'b0, -1, 16'h0);
      run_frame($sformatf("vec%0d f2", i), vecs[i], 1'b1, -1, 16'h0);
    end

    // Value change while digit 1 is lit: current frame unaffected.
    apply(vecs[0]);
    run_frame("tear f1", vecs[0], 1'b0, 6, 16'hABCD);
    run_frame("tear f2", vecs[4], 1'b1, -1, 16'h0);

    // Asynchronous reset during digit 2.
    apply(vecs[0]);
    for (int i = 0; i < 11; i++) step();
    check("mid digit2", 4'b1011, 7'h24, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    check_dark("reset mid-show async");
    value = 16'h5678;
    step();
    check_dark("reset mid-show held");
    reset = 1'b0;
    step();
    run_frame("post-reset", vecs[6], 1'b0, -1, 16'h0);

    // en dropped mid-digit, then re-enabled.
    step();
    step();
    check("pre-drop digit0", 4'b1110, 7'h00, 1'b1, 1'b0);
    en = 1'b0;
    step();
    check_dark("en drop edge");
    step();
    check_dark("en drop held");
    en = 1'b1;
    step();
    run_frame("re-enable", vecs[6], 1'b0, -1, 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
